// File: rtl/demux_sched.sv
// Scheduler for the 1-to-8 demux: steers a valid/ready sample stream to one of eight channels.
// Optional macro DEMUX_SCHED_DROP_CNT_EN adds a saturating drop_cnt output for masked mode-1 targets.
module demux_sched #(
    parameter int DW       = 8,
    parameter int RR_START = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          mode,
    input  logic [7:0]    ch_mask,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    input  logic [2:0]    s_addr,
    output logic [7:0]    m_valid,
    input  logic [7:0]    m_ready,
    output logic [DW-1:0] m_data,
    output logic [2:0]    sel,
    output logic          busy
`ifdef DEMUX_SCHED_DROP_CNT_EN
    ,
    output logic [7:0]    drop_cnt
`endif
);

    typedef enum logic {IDLE, HOLD} state_t;

    // Pointer resets one behind RR_START so the first round-robin search lands on it.
    localparam logic [2:0] PTR_RST = 3'((RR_START + 7) % 8);

    state_t        state_q;
    logic [DW-1:0] data_q;
    logic [2:0]    sel_q;
    logic [2:0]    ptr_q;
    logic [2:0]    ptr_d;
    logic [7:0]    m_valid_q;

    logic [2:0] tgt;
    logic       tgt_en;
    logic       target_ok;
    logic       deliver;
    logic       accept;
    logic       load;
    logic       found;
    logic [2:0] idx;

    always_comb begin
        ptr_d = ptr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= 8; i++) begin
            idx = ptr_q + 3'(i);
            if (!found && ch_mask[idx]) begin
                ptr_d = idx;
                found = 1'b1;
            end
        end
    end

    assign target_ok = mode | (|ch_mask);
    assign deliver   = (state_q == HOLD) && m_ready[sel_q];
    assign s_ready   = en && ((state_q == IDLE) || deliver) && target_ok;
    assign accept    = s_valid && s_ready;
    assign tgt       = mode ? s_addr : ptr_d;
    assign tgt_en    = ch_mask[tgt];
    // A masked mode-1 target is consumed but never loaded.
    assign load      = accept && tgt_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            data_q    <= '0;
            sel_q     <= '0;
            ptr_q     <= PTR_RST;
            m_valid_q <= '0;
        end else begin
            if (load) begin
                state_q   <= HOLD;
                data_q    <= s_data;
                sel_q     <= tgt;
                m_valid_q <= 8'(1) << tgt;
            end else if (deliver) begin
                state_q   <= IDLE;
                m_valid_q <= '0;
            end
            if (accept && !mode) begin
                ptr_q <= ptr_d;
            end
        end
    end

    assign m_valid = m_valid_q;
    assign m_data  = data_q;
    assign sel     = sel_q;
    assign busy    = (state_q == HOLD);

`ifdef DEMUX_SCHED_DROP_CNT_EN
    logic [7:0] drop_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= '0;
        end else if (accept && !tgt_en && drop_q != 8'hFF) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_demux_sched.sv
// Bench for demux_sched: directed scenarios plus random traffic against a transaction-level reference.
module tb_demux_sched;

    localparam int DW       = 8;
    localparam int RR_START = 0;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic          mode;
    logic [7:0]    ch_mask;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic [2:0]    s_addr;
    logic [7:0]    m_valid;
    logic [7:0]    m_ready;
    logic [DW-1:0] m_data;
    logic [2:0]    sel;
    logic          busy;
`ifdef DEMUX_SCHED_DROP_CNT_EN
    logic [7:0]    drop_cnt;
`endif

    demux_sched #(.DW(DW), .RR_START(RR_START)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .ch_mask (ch_mask),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_addr  (s_addr),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .sel     (sel),
        .busy    (busy)
`ifdef DEMUX_SCHED_DROP_CNT_EN
        ,
        .drop_cnt(drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: one held sample (or none), a last-served channel, a drop tally.
    int          r_last;
    bit          r_held;
    int          r_sel;
    logic [7:0]  r_data;
    int          r_drops;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int next_rr(input int last, input logic [7:0] mask);
        for (int k = 1; k <= 8; k++) begin
            if (mask[(last + k) % 8]) return (last + k) % 8;
        end
        return -1;
    endfunction

    function automatic bit ref_ready();
        bit can_take;
        can_take = !r_held || (m_ready[r_sel] == 1'b1);
        return en && can_take && (mode || ch_mask != 8'h00);
    endfunction

    task automatic ref_reset();
        r_last  = (RR_START + 7) % 8;
        r_held  = 0;
        r_sel   = 0;
        r_data  = '0;
        r_drops = 0;
    endtask

    // Check at the falling edge, then advance the reference across the rising edge.
    task automatic cycle();
        bit   rdy, acc, done;
        int   t;
        @(negedge clk);
        rdy = ref_ready();
        chk("s_ready", 32'(s_ready), 32'(rdy));
        chk("m_valid", 32'(m_valid), r_held ? (32'd1 << r_sel) : 32'd0);
        chk("m_data",  32'(m_data),  32'(r_data));
        chk("sel",     32'(sel),     32'(r_sel));
        chk("busy",    32'(busy),    32'(r_held));
`ifdef DEMUX_SCHED_DROP_CNT_EN
        chk("drop_cnt", 32'(drop_cnt), 32'(r_drops));
`endif
        acc  = s_valid && rdy;
        done = r_held && m_ready[r_sel];
        @(posedge clk);
        #1;
        if (acc) begin
            if (mode) t = int'(s_addr);
            else begin
                t = next_rr(r_last, ch_mask);
                r_last = t;
            end
            if (ch_mask[t]) begin
                r_held = 1;
                r_sel  = t;
                r_data = s_data;
            end else begin
                if (r_drops < 255) r_drops++;
                if (done) r_held = 0;
            end
        end else if (done) begin
            r_held = 0;
        end
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        ref_reset();
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_busy",    32'(busy),    32'd0);
        chk("rst_sel",     32'(sel),     32'd0);
        chk("rst_m_data",  32'(m_data),  32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [2:0] exp_seq [4];
    logic [2:0] ax      [4];

    initial begin
        en = 1'b1; mode = 1'b0; ch_mask = 8'hFF; s_valid = 1'b0;
        s_data = '0; s_addr = '0; m_ready = 8'hFF; rst_n = 1'b1;
        #3;
        apply_reset();

        // Round-robin walk over all channels at one sample per cycle.
        for (int i = 1; i <= 10; i++) begin
            s_valid = 1'b1; s_data = 8'(i);
            cycle();
            chk("walk_sel",  32'(sel),    32'((i - 1) % 8));
            chk("walk_data", 32'(m_data), 32'(i));
        end

        // Sparse mask: only channels 2, 5, 7 served.
        ch_mask = 8'b1010_0100;
        exp_seq = '{3'd2, 3'd5, 3'd7, 3'd2};
        for (int i = 0; i < 4; i++) begin
            s_data = 8'(8'h20 + i);
            cycle();
            chk("sparse_sel", 32'(sel), 32'(exp_seq[i]));
        end
        s_valid = 1'b0;
        cycle();

        // Addressed mode with a stalled channel 3.
        mode = 1'b1; ch_mask = 8'hFF; s_valid = 1'b1; s_addr = 3'd3; s_data = 8'hA5;
        m_ready = 8'hF7;
        cycle();
        s_data = 8'hB6;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("stall_m_valid", 32'(m_valid), 32'h08);
            chk("stall_m_data",  32'(m_data),  32'hA5);
            chk("stall_s_ready", 32'(s_ready), 32'd0);
        end
        m_ready = 8'hFF;
        cycle();
        chk("b2b_m_data", 32'(m_data), 32'hB6);
        s_valid = 1'b0;
        cycle();

        // Addressed mode with half the channels masked: two samples dropped.
        ch_mask = 8'h0F; s_valid = 1'b1;
        ax = '{3'd1, 3'd6, 3'd6, 3'd2};
        begin
            int drops0;
            drops0 = r_drops;
            for (int i = 0; i < 4; i++) begin
                s_addr = ax[i]; s_data = 8'(8'h40 + i);
                cycle();
            end
            s_valid = 1'b0;
            cycle();
            chk("drop_tally", 32'(r_drops - drops0), 32'd2);
        end
        chk("masked_last_sel", 32'(sel), 32'd2);

        // Round-robin with nothing enabled, then a single channel.
        mode = 1'b0; ch_mask = 8'h00; s_valid = 1'b1; s_data = 8'h77;
        repeat (3) cycle();
        chk("nomask_m_valid", 32'(m_valid), 32'd0);
        ch_mask = 8'h10;
        cycle();
        chk("single_sel",     32'(sel),     32'd4);
        chk("single_m_valid", 32'(m_valid), 32'h10);
        s_valid = 1'b0;
        cycle();

        // Reset while holding a sample for channel 5.
        mode = 1'b1; ch_mask = 8'hFF; m_ready = 8'h00; s_valid = 1'b1; s_addr = 3'd5; s_data = 8'h5A;
        cycle();
        s_valid = 1'b0;
        cycle();
        chk("pre_rst_m_valid", 32'(m_valid), 32'h20);
        #2;
        apply_reset();
        m_ready = 8'hFF; mode = 1'b0; s_valid = 1'b1; s_data = 8'h11;
        cycle();
        chk("post_rst_sel", 32'(sel), 32'(RR_START));
        s_valid = 1'b0;
        cycle();

        // Random traffic against the reference.
        for (int i = 0; i < 400; i++) begin
            en      = ($urandom_range(0, 7) != 0);
            mode    = 1'($urandom_range(0, 1));
            ch_mask = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            s_valid = 1'($urandom_range(0, 1));
            s_addr  = 3'($urandom);
            s_data  = 8'($urandom);
            m_ready = 8'($urandom);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_sched.md
Name: demux_sched

Overview:
- Sequencer for the 1-to-8 demux datapath: accepts a DW-bit sample stream with valid/ready and steers each sample to one of 8 output channels.
- Channel choice: round-robin over enabled channels (mode 0) or the per-sample address (mode 1).
- Holds one sample in an output register until the target channel accepts it.
- Drives `sel` for downstream demux instances and sits between the stream source and the channel consumers.

Parameters:
- DW, 8, sample data width
- RR_START, 0, first channel served after reset in round-robin mode (0..7)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  enable; 0 blocks new accepts
- mode  in  1  0 = round-robin, 1 = addressed
- ch_mask  in  8  per-channel enable, bit i = channel i
- s_valid  in  1  input sample valid
- s_ready  out  1  scheduler can accept sample
- s_data  in  DW  input sample
- s_addr  in  3  target channel (mode 1 only)
- m_valid  out  8  one-hot output valid
- m_ready  in  8  per-channel ready
- m_data  out  DW  shared output data bus
- sel  out  3  channel currently driven
- busy  out  1  output register occupied

Behaviour:
- Reset (rst_n=0, async):
  - state=IDLE, m_valid=0, m_data=0, sel=0, busy=0.
  - RR pointer = RR_START-1 mod 8, so the first RR target is RR_START.
  - Reset mid-transfer discards the held sample; there is no m_valid glitch after release.
- States: IDLE (register empty), HOLD (register full, m_valid[sel]=1).
- s_ready (combinational):
  - Condition: en AND (IDLE OR (HOLD AND m_ready[sel])) AND target_ok.
  - target_ok: mode0 needs ch_mask!=0; mode1 is always 1.
- Accept = s_valid AND s_ready.
- Target computation:
  - mode0: first set bit of ch_mask searching ptr+1, ptr+2, ... with wraparound mod 8. ptr updates to target on accept.
  - mode1: target = s_addr. ptr is unchanged.
- Accept with target enabled: next cycle m_data=s_data, sel=target, m_valid=onehot(target), state=HOLD. Latency is 1 cycle from accept to m_valid.
- Accept in mode1 with ch_mask[s_addr]=0: the sample is consumed and dropped. State and outputs are unchanged except the drop counter (optional feature).
- HOLD:
  - m_valid, m_data and sel stay stable until m_ready[sel]=1.
  - On the handshake: if accepting in the same cycle, load the new sample (back-to-back, 1 sample/cycle); else go to IDLE with m_valid=0.
  - m_ready of non-selected channels is ignored.
- ch_mask or mode change while in HOLD: the in-flight sample still completes to the latched sel. Changes apply to the next accept only.
- en=0 while in HOLD: the in-flight sample completes, then the block stays IDLE.
- busy = (state==HOLD).
- m_valid is never more than one-hot.

Optional Feature:
- Macro: DEMUX_SCHED_DROP_CNT_EN
- Defined:
  - Adds output port drop_cnt[7:0], reset 0.
  - Increments on each mode1 accept whose target is masked.
  - Saturates at 255.
  - No clear except reset.
- Undefined:
  - The port is absent.
  - Masked-target samples are still consumed and dropped silently.
  - All other behaviour is identical.

Test Plan:
- Reset release, mode0, ch_mask=8'hFF, m_ready=8'hFF, s_valid held with data 1..10 -> m_valid walks 01,02,04,...,80,01,02 at one sample/cycle; m_data=1..10; sel=0..7,0,1.
- mode0, ch_mask=8'b1010_0100, m_ready=all 1, 4 samples -> sel sequence 2,5,7,2; masked channels never see m_valid.
- mode1, m_ready[3]=0 for 5 cycles, sample A5 to addr 3 -> m_valid=08 and m_data=A5 held stable 5 cycles; s_ready=0 meanwhile; release -> handshake, next sample accepted the same cycle.
- mode1, ch_mask=8'h0F, addresses 1,6,6,2 -> channels 1 and 2 deliver; two samples dropped; drop_cnt=2 if DEMUX_SCHED_DROP_CNT_EN is defined.
- mode0, ch_mask=0 -> s_ready=0, no m_valid; then ch_mask=8'h10 -> next sample to channel 4.
- rst_n asserted low in HOLD (m_valid=20) -> m_valid=0 immediately; after release the first mode0 target is RR_START.
